// File: rtl/uart_alu_interface_pkg.sv
// rtl/uart_alu_interface_pkg.sv - shared FSM states, widths and ALU opcodes for the UART/ALU slice
package uart_alu_interface_pkg;

    localparam int DATA_WIDTH_DEF = 8;
    localparam int OP_WIDTH_DEF   = 6;

    // Frame assembly / transmit sequencing states
    typedef enum logic [2:0] {
        WAIT_A  = 3'd0,
        WAIT_B  = 3'd1,
        WAIT_OP = 3'd2,
        EXEC    = 3'd3,
        SEND    = 3'd4,
        WAIT_TX = 3'd5
    } state_e;

    // ALU opcodes (MIPS funct-style encodings)
    localparam logic [5:0] ALU_ADD = 6'b100000;
    localparam logic [5:0] ALU_SUB = 6'b100010;
    localparam logic [5:0] ALU_AND = 6'b100100;
    localparam logic [5:0] ALU_OR  = 6'b100101;
    localparam logic [5:0] ALU_XOR = 6'b100110;
    localparam logic [5:0] ALU_SRA = 6'b000011;
    localparam logic [5:0] ALU_SRL = 6'b000010;
    localparam logic [5:0] ALU_NOR = 6'b100111;

endpackage

// File: rtl/uart_alu_interface_frame_timer.sv
// rtl/uart_alu_interface_frame_timer.sv - RX silence counter that flags an abandoned partial frame
module frame_timer
    import uart_alu_interface_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT_CYCLES);
    // The counter would step to TIMEOUT_CYCLES-1 on the next edge; that edge is the expiry.
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 2);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expired_o = enable_i && !clear_i && (cnt_q == LAST);

    // Next count: clear wins, expiry restarts from zero, otherwise count while enabled
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || expired_o) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_alu_interface.sv
// rtl/uart_alu_interface.sv - assembles A/B/opcode frames from uart_rx, runs the ALU, hands result to uart_tx (option: RX_TIMEOUT_EN)
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int OP_WIDTH       = OP_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 5_000_000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_start,
    output logic                  o_busy,
    output logic                  o_timeout
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  timeout_q, timeout_d;
    logic                  rx_expired;

`ifdef RX_TIMEOUT_EN
    logic timer_en;
    logic timer_clr;

    // Only a partially received frame is timed; any byte that arrives restarts the window.
    assign timer_en  = (state_q == WAIT_B) || (state_q == WAIT_OP);
    assign timer_clr = !timer_en || i_rx_done;

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_timer (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (timer_clr),
        .enable_i (timer_en),
        .expired_o(rx_expired)
    );
`else
    assign rx_expired = 1'b0;
`endif

    // Next-state and datapath capture; a byte arriving in the expiry cycle beats the timeout
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tx_data_d = tx_data_q;
        timeout_d = 1'b0;
        case (state_q)
            WAIT_A: begin
                if (i_rx_done) begin
                    alu_a_d = i_rx_data;
                    state_d = WAIT_B;
                end
            end
            WAIT_B: begin
                if (i_rx_done) begin
                    alu_b_d = i_rx_data;
                    state_d = WAIT_OP;
                end else if (rx_expired) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end
            end
            WAIT_OP: begin
                if (i_rx_done) begin
                    alu_op_d = i_rx_data[OP_WIDTH-1:0];
                    state_d  = EXEC;
                end else if (rx_expired) begin
                    timeout_d = 1'b1;
                    state_d   = WAIT_A;
                end
            end
            EXEC: begin
                tx_data_d = i_alu_result;
                state_d   = SEND;
            end
            SEND: begin
                state_d = WAIT_TX;
            end
            WAIT_TX: begin
                if (i_tx_done) begin
                    state_d = WAIT_A;
                end
            end
            default: begin
                state_d = WAIT_A;
            end
        endcase
        tx_start_d = (state_d == SEND);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_op_q   <= alu_op_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_tx_start = tx_start_q;
    assign o_timeout  = timeout_q;
    assign o_busy     = (state_q == EXEC) || (state_q == SEND) || (state_q == WAIT_TX);

endmodule

// File: tb/tb_uart_alu_interface.sv
// tb/tb_uart_alu_interface.sv - self-checking bench for uart_alu_interface (vector table + scoreboard)
module tb_uart_alu_interface;
    import uart_alu_interface_pkg::*;

    logic       clk;
    logic       reset;
    logic       i_rx_done;
    logic [7:0] i_rx_data;
    logic [7:0] i_alu_result;
    logic       i_tx_done;
    logic [7:0] o_alu_a;
    logic [7:0] o_alu_b;
    logic [5:0] o_alu_op;
    logic [7:0] o_tx_data;
    logic       o_tx_start;
    logic       o_busy;
    logic       o_timeout;

    int n_cmp;
    int n_bad;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] op_byte;
        logic [5:0] exp_op;
        logic [7:0] exp_tx;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [5:0] op;
        logic [7:0] tx;
    } exp_t;

    exp_t sb_q[$];
    vec_t vecs[10];

    uart_alu_interface #(
        .DATA_WIDTH    (8),
        .OP_WIDTH      (6),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_rx_done   (i_rx_done),
        .i_rx_data   (i_rx_data),
        .i_alu_result(i_alu_result),
        .i_tx_done   (i_tx_done),
        .o_alu_a     (o_alu_a),
        .o_alu_b     (o_alu_b),
        .o_alu_op    (o_alu_op),
        .o_tx_data   (o_tx_data),
        .o_tx_start  (o_tx_start),
        .o_busy      (o_busy),
        .o_timeout   (o_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ALU driven by the DUT's registered operands
    always_comb begin
        case (o_alu_op)
            ALU_ADD: i_alu_result = o_alu_a + o_alu_b;
            ALU_SUB: i_alu_result = o_alu_a - o_alu_b;
            ALU_AND: i_alu_result = o_alu_a & o_alu_b;
            ALU_OR:  i_alu_result = o_alu_a | o_alu_b;
            ALU_XOR: i_alu_result = o_alu_a ^ o_alu_b;
            ALU_SRA: i_alu_result = $signed(o_alu_a) >>> o_alu_b[2:0];
            ALU_SRL: i_alu_result = o_alu_a >> o_alu_b[2:0];
            ALU_NOR: i_alu_result = ~(o_alu_a | o_alu_b);
            default: i_alu_result = 8'h00;
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every start pulse pops one expected frame
    logic prev_start = 1'b0;
    logic prev_tmo   = 1'b0;
    always @(negedge clk) begin
        if (o_tx_start) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_tx_start", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_tx_data", 32'(o_tx_data), 32'(e.tx));
                chk("sb_alu_a", 32'(o_alu_a), 32'(e.a));
                chk("sb_alu_b", 32'(o_alu_b), 32'(e.b));
                chk("sb_alu_op", 32'(o_alu_op), 32'(e.op));
            end
        end
        if (prev_start && o_tx_start) chk("tx_start_double", 32'd1, 32'd0);
        if (prev_tmo && o_timeout) chk("timeout_double", 32'd1, 32'd0);
        prev_start = o_tx_start;
        prev_tmo   = o_timeout;
    end

    task automatic send_byte(input logic [7:0] d);
        @(posedge clk);
        #1 i_rx_done = 1'b1;
        i_rx_data = d;
        @(posedge clk);
        #1 i_rx_done = 1'b0;
    endtask

    // Final byte of a frame: push expectation, check latency, hold, and complete with tx_done
    task automatic finish_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op_byte,
                                input logic [5:0] exp_op, input logic [7:0] exp_tx,
                                input logic inject_rx);
        exp_t e;
        int   cnt;
        e.a = a; e.b = b; e.op = exp_op; e.tx = exp_tx;
        sb_q.push_back(e);
        send_byte(op_byte);
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cnt++;
            if (o_tx_start) break;
        end
        chk("start_latency", 32'(cnt), 32'd2);
        chk("busy_in_send", 32'(o_busy), 32'd1);
        if (inject_rx) send_byte(8'hFF);
        repeat (3) @(negedge clk);
        chk("tx_data_hold", 32'(o_tx_data), 32'(exp_tx));
        chk("busy_wait_tx", 32'(o_busy), 32'd1);
        #1 i_tx_done = 1'b1;
        @(posedge clk);
        #1 i_tx_done = 1'b0;
        @(negedge clk);
        chk("busy_after_done", 32'(o_busy), 32'd0);
        chk("alu_a_kept", 32'(o_alu_a), 32'(a));
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_a"}, 32'(o_alu_a), 32'd0);
        chk({tag, "_b"}, 32'(o_alu_b), 32'd0);
        chk({tag, "_op"}, 32'(o_alu_op), 32'd0);
        chk({tag, "_tx"}, 32'(o_tx_data), 32'd0);
        chk({tag, "_start"}, 32'(o_tx_start), 32'd0);
        chk({tag, "_busy"}, 32'(o_busy), 32'd0);
        chk({tag, "_tmo"}, 32'(o_timeout), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int cnt;
        logic seen;
        n_cmp = 0;
        n_bad = 0;
        reset     = 1'b1;
        i_rx_done = 1'b0;
        i_rx_data = 8'h00;
        i_tx_done = 1'b0;

        vecs[0] = '{8'h6A, 8'h05, 8'h20, 6'h20, 8'h6F};
        vecs[1] = '{8'h6A, 8'h05, 8'hE2, 6'h22, 8'h65};
        vecs[2] = '{8'hF0, 8'h0F, 8'h24, 6'h24, 8'h00};
        vecs[3] = '{8'hF0, 8'h0F, 8'h25, 6'h25, 8'hFF};
        vecs[4] = '{8'hAA, 8'hFF, 8'h26, 6'h26, 8'h55};
        vecs[5] = '{8'h80, 8'h03, 8'h03, 6'h03, 8'hF0};
        vecs[6] = '{8'h80, 8'h03, 8'hC2, 6'h02, 8'h10};
        vecs[7] = '{8'h0F, 8'h30, 8'h27, 6'h27, 8'hC0};
        vecs[8] = '{8'hFF, 8'h02, 8'h60, 6'h20, 8'h01};
        vecs[9] = '{8'h10, 8'h20, 8'h22, 6'h22, 8'hF0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero("reset");
        #1 reset = 1'b0;

        // tx_done outside WAIT_TX has no effect
        @(posedge clk);
        #1 i_tx_done = 1'b1;
        @(posedge clk);
        #1 i_tx_done = 1'b0;
        @(negedge clk);
        chk("tx_done_idle_busy", 32'(o_busy), 32'd0);

        for (int i = 0; i < 10; i++) begin
            send_byte(vecs[i].a);
            send_byte(vecs[i].b);
            finish_frame(vecs[i].a, vecs[i].b, vecs[i].op_byte, vecs[i].exp_op, vecs[i].exp_tx, 1'b0);
        end

        // Byte arriving during WAIT_TX is dropped; next frame is unaffected
        send_byte(8'h6A);
        send_byte(8'h05);
        finish_frame(8'h6A, 8'h05, 8'h20, 6'h20, 8'h6F, 1'b1);
        send_byte(8'h01);
        send_byte(8'h02);
        finish_frame(8'h01, 8'h02, 8'h20, 6'h20, 8'h03, 1'b0);

        // Reset while waiting for the opcode
        send_byte(8'h44);
        send_byte(8'h55);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check_zero("mid_reset");
        send_byte(8'h09);
        send_byte(8'h04);
        finish_frame(8'h09, 8'h04, 8'h22, 6'h22, 8'h05, 1'b0);

        // One byte then silence
        send_byte(8'h33);
        cnt  = 0;
        seen = 1'b0;
`ifdef RX_TIMEOUT_EN
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_timeout) begin
                seen = 1'b1;
                break;
            end
            cnt++;
        end
        chk("timeout_seen", 32'(seen), 32'd1);
        chk("timeout_delay", 32'(cnt), 32'd15);
        chk("timeout_a_kept", 32'(o_alu_a), 32'h33);
        @(negedge clk);
        chk("timeout_one_cycle", 32'(o_timeout), 32'd0);
        send_byte(8'h21);
        send_byte(8'h12);
        finish_frame(8'h21, 8'h12, 8'h20, 6'h20, 8'h33, 1'b0);
`else
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (o_timeout) seen = 1'b1;
            cnt++;
        end
        chk("no_timeout", 32'(seen), 32'd0);
        chk("no_timeout_busy", 32'(o_busy), 32'd0);
        send_byte(8'h12);
        finish_frame(8'h33, 8'h12, 8'h20, 6'h20, 8'h45, 1'b0);
`endif

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
